// File: rtl/mult_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mult_operand_ctrl
// Brief   : Operand capture and start/done sequencer for the signed multiplier.
// Revision: 1.0
// ============================================================================
module mult_operand_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_load,
    input  logic                 btn_clear,
    input  logic [WIDTH-1:0]     sw,
    input  logic                 mult_done,
    input  logic [2*WIDTH-1:0]   mult_product,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic                 mult_start,
    output logic [2*WIDTH-1:0]   product,
    output logic                 result_valid,
    output logic                 err,
    output logic [2:0]           state
);

    localparam int c_CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT_A = 3'd0,
        S_WAIT_B = 3'd1,
        S_BUSY   = 3'd2,
        S_SHOW   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_load_q;
    logic                 r_clear_q;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic                 r_start;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_valid;
    logic                 r_err;
    logic [c_CW-1:0]      r_cnt;

    logic                 w_load_ev;
    logic                 w_clear_ev;

    // Edge registers reset high so a button held through reset is not an event.
    assign w_load_ev  = btn_load  & ~r_load_q;
    assign w_clear_ev = btn_clear & ~r_clear_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_WAIT_A;
            r_load_q  <= 1'b1;
            r_clear_q <= 1'b1;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_start   <= 1'b0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_load_q  <= btn_load;
            r_clear_q <= btn_clear;
            r_start   <= 1'b0;
            if (w_clear_ev) begin
                r_op_a    <= '0;
                r_op_b    <= '0;
                r_product <= '0;
                r_valid   <= 1'b0;
                r_err     <= 1'b0;
                r_state   <= S_WAIT_A;
            end else begin
                case (r_state)
                    S_WAIT_A: begin
                        if (w_load_ev) begin
                            r_op_a  <= sw;
                            r_state <= S_WAIT_B;
                        end
                    end
                    S_WAIT_B: begin
                        if (w_load_ev) begin
                            r_op_b  <= sw;
                            r_start <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        r_cnt <= r_cnt + c_CW'(1);
                        // Done takes priority over a coincident timeout.
                        if (mult_done) begin
                            r_product <= mult_product;
                            r_valid   <= 1'b1;
                            r_state   <= S_SHOW;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                    S_SHOW: begin
                        if (w_load_ev) begin
                            r_op_a  <= sw;
                            r_valid <= 1'b0;
                            r_state <= S_WAIT_B;
                        end
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_WAIT_A;
                    end
                endcase
            end
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign mult_start   = r_start;
    assign product      = r_product;
    assign result_valid = r_valid;
    assign err          = r_err;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mult_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_operand_ctrl
// Brief   : Directed self-checking bench for mult_operand_ctrl.
// Revision: 1.0
// ============================================================================
module tb_mult_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_load;
    logic        btn_clear;
    logic [7:0]  sw;
    logic        mult_done;
    logic [15:0] mult_product;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        mult_start;
    logic [15:0] product;
    logic        result_valid;
    logic        err;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    mult_operand_ctrl #(.WIDTH(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_load     (btn_load),
        .btn_clear    (btn_clear),
        .sw           (sw),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .op_a         (op_a),
        .op_b         (op_b),
        .mult_start   (mult_start),
        .product      (product),
        .result_valid (result_valid),
        .err          (err),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_load = 1'b1; btn_clear = 1'b0; sw = 8'h00;
        mult_done = 1'b0; mult_product = 16'h0;
        tick; tick;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if ({op_a, op_b, product} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {op_a, op_b, product}); end
        n_checks++; if ({mult_start, result_valid, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {mult_start, result_valid, err}); end
        rst = 1'b0;
        sw = 8'h77;
        tick; tick; tick;
        n_checks++; if (state !== 3'd0 || op_a !== 8'h00) begin n_fail++; $display("FAIL held_load_no_event: got state %0d op_a %h expected 0 00", state, op_a); end
        btn_load = 1'b0; tick;
        sw = 8'h33; btn_load = 1'b1; tick;
        n_checks++; if (state !== 3'd1 || op_a !== 8'h33) begin n_fail++; $display("FAIL first_load: got state %0d op_a %h expected 1 33", state, op_a); end
        btn_load = 1'b0; tick;
        btn_clear = 1'b1; tick;
        n_checks++; if (state !== 3'd0 || op_a !== 8'h00) begin n_fail++; $display("FAIL clear_wait_b: got state %0d op_a %h expected 0 00", state, op_a); end
        btn_clear = 1'b0; tick;
    endtask

    task automatic test_multiply;
        sw = 8'h05; btn_load = 1'b1; tick;
        n_checks++; if (state !== 3'd1 || op_a !== 8'h05) begin n_fail++; $display("FAIL load_a: got state %0d op_a %h expected 1 05", state, op_a); end
        btn_load = 1'b0; tick;
        sw = 8'hFD; btn_load = 1'b1; tick;
        n_checks++; if (state !== 3'd2 || op_b !== 8'hFD || op_a !== 8'h05 || mult_start !== 1'b1) begin n_fail++; $display("FAIL load_b: got state %0d a %h b %h start %b expected 2 05 fd 1", state, op_a, op_b, mult_start); end
        btn_load = 1'b0; tick;
        n_checks++; if (mult_start !== 1'b0 || state !== 3'd2) begin n_fail++; $display("FAIL start_one_cycle: got start %b state %0d expected 0 2", mult_start, state); end
        mult_done = 1'b1; mult_product = 16'hFFF1; tick;
        mult_done = 1'b0; mult_product = 16'h0000;
        n_checks++; if (state !== 3'd3 || product !== 16'hFFF1 || result_valid !== 1'b1) begin n_fail++; $display("FAIL done_capture: got state %0d product %h valid %b expected 3 fff1 1", state, product, result_valid); end
        tick;
        n_checks++; if (state !== 3'd3 || product !== 16'hFFF1) begin n_fail++; $display("FAIL show_hold: got state %0d product %h expected 3 fff1", state, product); end
    endtask

    task automatic test_show_load;
        sw = 8'h80; btn_load = 1'b1; tick;
        n_checks++; if (state !== 3'd1 || op_a !== 8'h80 || result_valid !== 1'b0 || product !== 16'hFFF1) begin n_fail++; $display("FAIL show_load: got state %0d a %h valid %b product %h expected 1 80 0 fff1", state, op_a, result_valid, product); end
        btn_load = 1'b0; tick;
    endtask

    task automatic test_timeout;
        int busy_cycles;
        sw = 8'h02; btn_load = 1'b1; tick;
        busy_cycles = (state == 3'd2) ? 1 : 0;
        btn_load = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 10) btn_load = 1'b1;
            if (i == 11) btn_load = 1'b0;
            tick;
            if (state == 3'd2) busy_cycles++;
        end
        n_checks++; if (busy_cycles !== 64) begin n_fail++; $display("FAIL busy_length: got %0d cycles expected 64", busy_cycles); end
        n_checks++; if (state !== 3'd4 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got state %0d err %b expected 4 1", state, err); end
        btn_load = 1'b1; tick;
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL err_ignores_load: got state %0d expected 4", state); end
        btn_load = 1'b0; tick;
        btn_clear = 1'b1; tick;
        n_checks++; if (state !== 3'd0 || err !== 1'b0 || product !== 16'h0000 || op_a !== 8'h00 || op_b !== 8'h00) begin n_fail++; $display("FAIL err_clear: got state %0d err %b product %h a %h b %h expected 0 0 0000 00 00", state, err, product, op_a, op_b); end
        btn_clear = 1'b0; tick;
    endtask

    task automatic test_abort;
        sw = 8'h03; btn_load = 1'b1; tick; btn_load = 1'b0; tick;
        sw = 8'h04; btn_load = 1'b1; tick; btn_load = 1'b0; tick;
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL abort_setup: got state %0d expected 2", state); end
        btn_clear = 1'b1; mult_done = 1'b1; mult_product = 16'h1234; tick;
        n_checks++; if (state !== 3'd0 || product !== 16'h0000 || result_valid !== 1'b0) begin n_fail++; $display("FAIL abort_clear_wins: got state %0d product %h valid %b expected 0 0000 0", state, product, result_valid); end
        btn_clear = 1'b0; tick;
        mult_done = 1'b0; mult_product = 16'h0000;
        n_checks++; if (state !== 3'd0 || product !== 16'h0000 || result_valid !== 1'b0) begin n_fail++; $display("FAIL late_done: got state %0d product %h valid %b expected 0 0000 0", state, product, result_valid); end
    endtask

    task automatic test_load_clear_same;
        sw = 8'h11; btn_load = 1'b1; tick; btn_load = 1'b0; tick;
        sw = 8'h22; btn_load = 1'b1; btn_clear = 1'b1; tick;
        n_checks++; if (state !== 3'd0 || op_b !== 8'h00 || op_a !== 8'h00 || mult_start !== 1'b0) begin n_fail++; $display("FAIL load_clear_same: got state %0d a %h b %h start %b expected 0 00 00 0", state, op_a, op_b, mult_start); end
        btn_load = 1'b0; btn_clear = 1'b0; tick;
        n_checks++; if (state !== 3'd0 || mult_start !== 1'b0) begin n_fail++; $display("FAIL load_clear_after: got state %0d start %b expected 0 0", state, mult_start); end
    endtask

    task automatic test_done_at_timeout;
        sw = 8'h7F; btn_load = 1'b1; tick; btn_load = 1'b0; tick;
        sw = 8'hFF; btn_load = 1'b1; tick;
        btn_load = 1'b0;
        repeat (63) tick;
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL last_busy_cycle: got state %0d expected 2", state); end
        mult_done = 1'b1; mult_product = 16'hFF81; tick;
        mult_done = 1'b0; mult_product = 16'h0000;
        n_checks++; if (state !== 3'd3 || err !== 1'b0 || product !== 16'hFF81 || result_valid !== 1'b1) begin n_fail++; $display("FAIL done_beats_timeout: got state %0d err %b product %h valid %b expected 3 0 ff81 1", state, err, product, result_valid); end
    endtask

    task automatic test_async_reset;
        btn_clear = 1'b1; tick; btn_clear = 1'b0; tick;
        sw = 8'h55; btn_load = 1'b1; tick; btn_load = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (state !== 3'd0 || op_a !== 8'h00 || product !== 16'h0000 || result_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got state %0d a %h product %h valid %b expected 0 00 0000 0", state, op_a, product, result_valid); end
        #2 rst = 1'b0;
        tick;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL after_async_reset: got state %0d expected 0", state); end
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_show_load;
        test_timeout;
        test_abort;
        test_load_clear_same;
        test_done_at_timeout;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
